// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller between a CPU handshake and a RAM.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_dm #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 4,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              gen_reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int LINES = 2 ** INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

   typedef enum logic [1:0] {IDLE, READ_MEM, WRITE_MEM, RESP} state_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                hit_q, hit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [LINES];

   logic [INDEX_W-1:0]  req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                lookup_hit;
   logic [INDEX_W-1:0]  line_idx;
   logic                line_we;
   logic                tag_we;
   logic [DATA_W-1:0]   line_data;

   assign req_idx    = cpu_addr[INDEX_W-1:0];
   assign req_tag    = cpu_addr[ADDR_W-1:INDEX_W];
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign line_idx   = addr_q[INDEX_W-1:0];

   always_ff @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_we)          state_d = WRITE_MEM;
               else if (lookup_hit) state_d = RESP;
               else                 state_d = READ_MEM;
            end
         end
         READ_MEM:  if (cnt_q == CNT_LAST) state_d = RESP;
         WRITE_MEM: state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      hit_d     = hit_q;
      cnt_d     = cnt_q;
      line_we   = 1'b0;
      tag_we    = 1'b0;
      line_data = mem_rdata;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               hit_d   = lookup_hit;
               cnt_d   = '0;
               if (!cpu_we && lookup_hit) rdata_d = data_mem[req_idx];
               // The victim line stays invalid until its refill completes.
               if (!cpu_we && !lookup_hit) valid_d[req_idx] = 1'b0;
            end
         end
         READ_MEM: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               rdata_d           = mem_rdata;
               valid_d[line_idx] = 1'b1;
               line_we           = 1'b1;
               tag_we            = 1'b1;
            end
         end
         WRITE_MEM: begin
            if (hit_q) begin
               line_we   = 1'b1;
               line_data = wdata_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         valid_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) data_mem[line_idx] <= line_data;
      if (tag_we)  tag_mem[line_idx]  <= addr_q[ADDR_W-1:INDEX_W];
   end

   always_comb begin
      cpu_ready = (state_q == RESP);
      cpu_hit   = (state_q == RESP) && hit_q;
      cpu_rdata = rdata_q;
      mem_re    = (state_q == READ_MEM);
      mem_we    = (state_q == WRITE_MEM);
      mem_addr  = (state_q == READ_MEM || state_q == WRITE_MEM) ? addr_q : '0;
      mem_wdata = (state_q == WRITE_MEM) ? wdata_q : '0;
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == RESP) begin
         if (hit_q && hit_cnt_q != 16'hFFFF)         hit_cnt_d  = hit_cnt_q + 16'd1;
         else if (!hit_q && miss_cnt_q != 16'hFFFF)  miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge gen_reset) begin
      if (gen_reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Scoreboard bench for cache_ctrl_dm: a cache-contents model predicts hit/latency/data per request,
// and a monitor checks every response and every RAM-port cycle against it.
module tb_cache_ctrl_dm;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int INDEX_W = 4;
   localparam int MEM_LAT = 1;
   localparam int LINES   = 2 ** INDEX_W;
   localparam int WORDS   = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              gen_reset;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready, cpu_hit;
   logic [DATA_W-1:0] cpu_rdata;
   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [15:0]       hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_ctrl_dm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .gen_reset(gen_reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   // RAM attached to the controller: read data registered one edge after read_enable.
   logic [DATA_W-1:0] ram [WORDS];
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   // Reference: memory contents plus which full address each line currently holds (-1 = empty).
   logic [DATA_W-1:0] ref_ram [WORDS];
   int                line_addr [LINES];
   int                exp_hits, exp_misses;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
      logic              hit;
      logic [DATA_W-1:0] rdata;
      int                lat;
      int                re_cyc;
      int                we_cyc;
   } exp_t;
   exp_t q[$];
   exp_t cur;

   int n_assert = 0;
   int n_fail   = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: RAM-port rules every cycle, response check whenever cpu_ready is seen.
   int cyc = 0, re_cnt = 0, we_cnt = 0;
   always @(negedge clk) begin
      if (gen_reset) begin
         cyc = 0; re_cnt = 0; we_cnt = 0;
      end else begin
         chk("mem_both_strobes", 64'(mem_re & mem_we), 0);
         if (!mem_re && !mem_we) begin
            chk("mem_addr_idle", 64'(mem_addr), 0);
            chk("mem_wdata_idle", 64'(mem_wdata), 0);
         end
         if (q.size() > 0) begin
            if (cpu_req) cyc++;
            if (mem_re) begin
               re_cnt++;
               chk("mem_re_addr", 64'(mem_addr), 64'(q[0].addr));
            end
            if (mem_we) begin
               we_cnt++;
               chk("mem_we_addr", 64'(mem_addr), 64'(q[0].addr));
               chk("mem_we_data", 64'(mem_wdata), 64'(q[0].wdata));
            end
            if (cpu_ready) begin
               cur = q.pop_front();
               chk("cpu_hit", 64'(cpu_hit), 64'(cur.hit));
               chk("latency", 64'(cyc - 1), 64'(cur.lat));
               chk("mem_re_cycles", 64'(re_cnt), 64'(cur.re_cyc));
               chk("mem_we_cycles", 64'(we_cnt), 64'(cur.we_cyc));
               if (!cur.we) chk("cpu_rdata", 64'(cpu_rdata), 64'(cur.rdata));
               $display("txn %s addr=0x%03h hit=%0d lat=%0d rdata=0x%08h",
                        cur.we ? "WR" : "RD", cur.addr, cpu_hit, cyc - 1, cpu_rdata);
               cyc = 0; re_cnt = 0; we_cnt = 0;
            end
         end else if (cpu_ready) begin
            chk("unexpected_ready", 64'(cpu_ready), 0);
         end
      end
   end

   task automatic do_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      exp_t e;
      int   idx = int'(addr[INDEX_W-1:0]);
      int   waited = 0;
      e.addr   = addr;
      e.we     = we;
      e.wdata  = wdata;
      e.hit    = (line_addr[idx] == int'(addr));
      e.rdata  = ref_ram[addr];
      e.lat    = we ? 2 : (e.hit ? 1 : MEM_LAT + 2);
      e.re_cyc = (!we && !e.hit) ? MEM_LAT + 1 : 0;
      e.we_cyc = we ? 1 : 0;
      if (we) ref_ram[addr] = wdata;
      else if (!e.hit) line_addr[idx] = int'(addr);
      if (e.hit) exp_hits++; else exp_misses++;
      q.push_back(e);
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
      do begin
         @(negedge clk);
         waited++;
      end while (!cpu_ready && waited < 20);
      if (!cpu_ready) begin
         chk("ready_timeout", 64'(cpu_ready), 1);
         q.delete();
      end
      @(posedge clk);
      #1 cpu_req = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) line_addr[i] = -1;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_stats();
`ifdef CACHE_STATS_EN
      chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
      chk("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`endif
   endtask

   initial begin
      int waited;
      logic [ADDR_W-1:0] a;
      gen_reset = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      for (int i = 0; i < WORDS; i++) begin
         ram[i]     = $urandom;
         ref_ram[i] = ram[i];
      end
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_ready", 64'(cpu_ready), 0);
      chk("rst_cpu_hit", 64'(cpu_hit), 0);
      chk("rst_cpu_rdata", 64'(cpu_rdata), 0);
      chk("rst_mem_re", 64'(mem_re), 0);
      chk("rst_mem_we", 64'(mem_we), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      check_stats();
      @(posedge clk);
      #1 gen_reset = 1'b0;
      @(posedge clk);
      #1;

      do_txn(1'b0, 10'h005, '0);
      do_txn(1'b0, 10'h005, '0);
      do_txn(1'b1, 10'h005, 32'hDEADBEEF);
      do_txn(1'b0, 10'h005, '0);
      do_txn(1'b0, 10'h015, '0);
      do_txn(1'b0, 10'h005, '0);
      do_txn(1'b1, 10'h0A3, 32'h12345678);
      do_txn(1'b0, 10'h0A3, '0);
      check_stats();

      // Small address pool so hits, conflicts and write hits all occur often.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
         else a = ADDR_W'(($urandom_range(0, 5) << INDEX_W) | $urandom_range(0, 3));
         do_txn(($urandom_range(0, 2) == 0), a, $urandom);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      check_stats();

      // Reset in the middle of a refill of 0x015.
      do_txn(1'b0, 10'h005, '0);
      cpu_we   = 1'b0;
      cpu_addr = 10'h015;
      cpu_req  = 1'b1;
      waited   = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!mem_re && waited < 10);
      chk("refill_started", 64'(mem_re), 1);
      #1 gen_reset = 1'b1;
      #1;
      chk("midrst_mem_re", 64'(mem_re), 0);
      chk("midrst_cpu_ready", 64'(cpu_ready), 0);
      chk("midrst_mem_addr", 64'(mem_addr), 0);
      q.delete();
      model_reset();
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_ready", 64'(cpu_ready), 0);
      end
      @(posedge clk);
      #1;
      cpu_req   = 1'b0;
      gen_reset = 1'b0;
      check_stats();
      @(posedge clk);
      #1;
      do_txn(1'b0, 10'h015, '0);
      do_txn(1'b0, 10'h015, '0);
      do_txn(1'b0, 10'h005, '0);
      check_stats();
      chk("queue_drained", 64'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
